instr_fetch_buffer: RTL and testbench

//  Fetch front-end directly upstream of the single-cycle datapath: supplies Instr and its PC.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_fifo_chk.sv | 16 +
 rtl/instr_fetch_buffer.sv | 155 +++++++++++++++
 tb/tb_instr_fetch_buffer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc,instr} entries with a flush (clear) input.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_entry_t       mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               do_push_s;
    logic               do_pop_s;

    // Status flags and guarded handshakes.
    always_comb begin
        full      = (count_r == DEPTH_C);
        empty     = (count_r == {CNT_W{1'b0}});
        count     = count_r;
        head      = mem_r[rd_ptr_r];
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
    end

    // Pointer and occupancy bookkeeping; clear empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents beyond the valid window are don't-care.
    always_ff @(posedge clk) begin
        if (do_push_s && !clear) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_fifo_chk.sv
// Checker: a kept response must never find the prefetch FIFO already full.
module fetch_fifo_chk (
    input logic clk,
    input logic reset,
    input logic push,
    input logic full
);

    // Credit accounting is meant to make this unreachable.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(push && full)) else $error("fetch_fifo overflow: response pushed while full");
        end
    end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch front-end: sequential prefetch into a FIFO with redirect flush.
// Optional FETCH_PERF_CNT_EN adds perf_stall_cnt / perf_flush_cnt outputs.
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};

    logic [31:0]      fetch_pc_r;
    logic [31:0]      rsp_pc_r;
    logic [CNT_W-1:0] outst_r;
    logic [CNT_W-1:0] drop_r;
    logic [CNT_W-1:0] outst_next_s;
    logic [CNT_W:0]   occupancy_s;
    logic             req_valid_s;
    logic             req_fire_s;
    logic             keep_s;
    logic             pop_s;
    fetch_entry_t     push_entry_s;
    fetch_entry_t     head_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;

    // Credit check: every accepted request must already own a FIFO slot.
    always_comb begin
        occupancy_s  = {1'b0, outst_r} + {1'b0, fifo_count_s};
        req_valid_s  = !reset && (occupancy_s < {1'b0, DEPTH_C}) && (outst_r < MAX_C);
        req_fire_s   = req_valid_s && imem_req_ready;
        keep_s       = imem_rsp_valid && (drop_r == ZERO_C) && !redirect_valid;
        pop_s        = !fifo_empty_s && instr_ready && !redirect_valid;
        push_entry_s = '{pc: rsp_pc_r, instr: imem_rsp_data};
        case ({req_fire_s, imem_rsp_valid})
            2'b10:   outst_next_s = outst_r + CNT_W'(1);
            2'b01:   outst_next_s = outst_r - CNT_W'(1);
            default: outst_next_s = outst_r;
        endcase
    end

    // Fetch/response PCs and in-flight accounting; a redirect marks every
    // live request, including one accepted this cycle, as wrong-path.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r <= RESET_PC;
            rsp_pc_r   <= RESET_PC;
            outst_r    <= ZERO_C;
            drop_r     <= ZERO_C;
        end else begin
            outst_r <= outst_next_s;
            if (redirect_valid) begin
                drop_r     <= outst_next_s;
                fetch_pc_r <= align_pc(redirect_pc);
                rsp_pc_r   <= align_pc(redirect_pc);
            end else begin
                if (imem_rsp_valid && (drop_r != ZERO_C)) begin
                    drop_r <= drop_r - CNT_W'(1);
                end
                if (req_fire_s) begin
                    fetch_pc_r <= fetch_pc_r + PC_STEP;
                end
                if (keep_s) begin
                    rsp_pc_r <= rsp_pc_r + PC_STEP;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (keep_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    fetch_fifo_chk u_fifo_chk (
        .clk   (clk),
        .reset (reset),
        .push  (keep_s),
        .full  (fifo_full_s)
    );

    // Datapath-facing outputs are driven from FIFO state; zeroed when empty.
    always_comb begin
        imem_req_valid = req_valid_s;
        imem_req_addr  = fetch_pc_r;
        instr_valid    = !fifo_empty_s;
        if (!fifo_empty_s) begin
            instr    = head_s.instr;
            instr_pc = head_s.pc;
        end else begin
            instr    = NOP_INSTR;
            instr_pc = 32'h0000_0000;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Saturating counters of starved consume cycles and redirects.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (instr_ready && fifo_empty_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (redirect_valid && (flush_cnt_r != 32'hFFFF_FFFF)) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_r;
    assign perf_flush_cnt = flush_cnt_r;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed self-checking bench for instr_fetch_buffer with a latency-programmable memory model.
module tb_instr_fetch_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_bad = 0;
    int mem_lat = 0;
    int unsigned cyc = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
    } mreq_t;
    mreq_t mq[$];

    always #5 clk = ~clk;

    instr_fetch_buffer #(.DEPTH(DEPTH), .MAX_OUTST(2), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // In-order memory: responds mem_lat cycles after acceptance, one per cycle.
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
        end else begin
            if (imem_req_valid && imem_req_ready) mq.push_back({imem_req_addr, cyc + 32'(mem_lat)});
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mem_word(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
        cyc <= cyc + 1;
    end

    task automatic do_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        instr_ready = 1'b0; imem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        mem_lat = 0;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        instr_ready = 1'b1; imem_req_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", instr); end
        n_cmp++; if (instr_pc !== 32'h0) begin n_bad++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
        reset = 1'b0;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL post_reset_req_valid: got %b want 1", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL post_reset_req_addr: got %h want 0", imem_req_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc = 32'h0;
        mem_lat = 0;
        do_reset();
        instr_ready = 1'b1;
        for (int k = 0; k < 10 && !instr_valid; k++) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
                n_bad++; $display("FAIL stream_%0d: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", i, instr_valid, instr_pc, instr, exp_pc, mem_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc = 32'h0;
        int seen = 0;
        mem_lat = 0;
        do_reset();
        repeat (10) @(negedge clk);
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin n_bad++; $display("FAIL stall_head: got v=%b pc=%h want v=1 pc=0", instr_valid, instr_pc); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL stall_req_valid: got %b want 0", imem_req_valid); end
        imem_req_ready = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
                n_bad++; $display("FAIL stall_drain_%0d: got v=%b pc=%h want v=1 pc=%h", i, instr_valid, instr_pc, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
            @(negedge clk);
        end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL stall_exact_depth: got v=%b want 0", instr_valid); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin n_bad++; $display("FAIL stall_resume_addr: got v=%b addr=%h want v=1 addr=10", imem_req_valid, imem_req_addr); end
        imem_req_ready = 1'b1;
        for (int k = 0; k < 40 && seen < 3; k++) begin
            if (instr_valid) begin
                n_cmp++; if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin n_bad++; $display("FAIL stall_resume_%0d: got pc=%h want pc=%h", seen, instr_pc, exp_pc); end
                exp_pc = exp_pc + 32'd4;
                seen++;
            end
            @(negedge clk);
        end
        n_cmp++; if (seen !== 3) begin n_bad++; $display("FAIL stall_resume_timeout: got %0d instrs want 3", seen); end
    endtask

    task automatic test_redirect_drop();
        logic [31:0] exp_pc = 32'h100;
        int seen = 0;
        mem_lat = 3;
        do_reset();
        instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL max_outst_block: got %b want 0", imem_req_valid); end
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int k = 0; k < 60 && seen < 3; k++) begin
            if (instr_valid) begin
                n_cmp++; if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin n_bad++; $display("FAIL redirect_drop_%0d: got pc=%h ins=%h want pc=%h ins=%h", seen, instr_pc, instr, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                seen++;
            end
            @(negedge clk);
        end
        n_cmp++; if (seen !== 3) begin n_bad++; $display("FAIL redirect_drop_timeout: got %0d instrs want 3", seen); end
        mem_lat = 0;
    endtask

    task automatic test_redirect_align();
        logic [31:0] exp_pc = 32'h200;
        int seen = 0;
        mem_lat = 0;
        do_reset();
        repeat (6) @(negedge clk);
        instr_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL redirect_flush_valid: got %b want 0", instr_valid); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_bad++; $display("FAIL redirect_align_addr: got v=%b addr=%h want v=1 addr=200", imem_req_valid, imem_req_addr); end
        repeat (2) @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_bad++; $display("FAIL req_addr_stable: got v=%b addr=%h want v=1 addr=200", imem_req_valid, imem_req_addr); end
        imem_req_ready = 1'b1;
        for (int k = 0; k < 20 && seen < 2; k++) begin
            if (instr_valid) begin
                n_cmp++; if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin n_bad++; $display("FAIL redirect_align_%0d: got pc=%h want pc=%h", seen, instr_pc, exp_pc); end
                exp_pc = exp_pc + 32'd4;
                seen++;
            end
            @(negedge clk);
        end
        n_cmp++; if (seen !== 2) begin n_bad++; $display("FAIL redirect_align_timeout: got %0d instrs want 2", seen); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc = 32'hFFFF_FFF8;
        int seen = 0;
        mem_lat = 0;
        do_reset();
        instr_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int k = 0; k < 30 && seen < 4; k++) begin
            if (instr_valid) begin
                n_cmp++; if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin n_bad++; $display("FAIL wrap_%0d: got pc=%h ins=%h want pc=%h ins=%h", seen, instr_pc, instr, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                seen++;
            end
            @(negedge clk);
        end
        n_cmp++; if (seen !== 4) begin n_bad++; $display("FAIL wrap_timeout: got %0d instrs want 4", seen); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_pc = 32'h0;
        int seen = 0;
        mem_lat = 0;
        do_reset();
        instr_ready = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc === 32'h0) begin n_bad++; $display("FAIL midreset_running: got v=%b pc=%h want v=1 pc!=0", instr_valid, instr_pc); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (instr_valid !== 1'b0 || instr_pc !== 32'h0 || instr !== 32'h0) begin n_bad++; $display("FAIL midreset_cleared: got v=%b pc=%h ins=%h want 0/0/0", instr_valid, instr_pc, instr); end
        reset = 1'b0;
        for (int k = 0; k < 20 && seen < 3; k++) begin
            if (instr_valid) begin
                n_cmp++; if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin n_bad++; $display("FAIL midreset_refetch_%0d: got pc=%h want pc=%h", seen, instr_pc, exp_pc); end
                exp_pc = exp_pc + 32'd4;
                seen++;
            end
            @(negedge clk);
        end
        n_cmp++; if (seen !== 3) begin n_bad++; $display("FAIL midreset_timeout: got %0d instrs want 3", seen); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_align();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
